// File: rtl/inst_enc_pkg.sv
// Shared types, RV32I opcodes and immediate helpers for the instruction encoder.
package inst_enc_pkg;

  typedef enum logic [2:0] {K_R, K_I, K_S, K_B, K_U, K_J, K_LI, K_FAR} enc_kind_e;
  typedef enum logic [1:0] {S_IDLE, S_WORD0, S_WORD1} enc_state_e;

  localparam logic [6:0] OP_LOAD    = 7'h03;
  localparam logic [6:0] OP_ART_IMM = 7'h13;
  localparam logic [6:0] OP_AUIPC   = 7'h17;
  localparam logic [6:0] OP_STORE   = 7'h23;
  localparam logic [6:0] OP_ART_REG = 7'h33;
  localparam logic [6:0] OP_LUI     = 7'h37;
  localparam logic [6:0] OP_BRANCH  = 7'h63;
  localparam logic [6:0] OP_JALR    = 7'h67;
  localparam logic [6:0] OP_JAL     = 7'h6F;
  localparam logic [2:0] F3_ADD     = 3'h0;

  typedef struct packed {
    enc_kind_e   kind;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } pack_req_t;

  // True when imm is representable as a sign-extended 'bits'-wide field.
  function automatic logic fits_signed(input logic [31:0] imm, input int bits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++)
      if (i >= bits - 1 && imm[i] != imm[31]) ok = 1'b0;
    return ok;
  endfunction

  // Upper 20 bits rounded so that a following sign-extended low-12 add lands on imm.
  function automatic logic [19:0] hi20_round(input logic [31:0] imm);
    logic [31:0] s;
    s = imm + 32'h0000_0800;
    return s[31:12];
  endfunction

endpackage

// File: rtl/inst_field_pack.sv
// Combinational RV32I field packer for one word plus its immediate range check.
module inst_field_pack
  import inst_enc_pkg::*;
#(
  parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
  input  logic [2:0]  kind,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        range_err
);

  always_comb begin
    inst      = RESET_INST;
    range_err = 1'b1;
    case (enc_kind_e'(kind))
      K_R: begin
        inst      = {funct7, rs2, rs1, funct3, rd, opcode};
        range_err = 1'b0;
      end
      K_I: begin
        inst      = {imm[11:0], rs1, funct3, rd, opcode};
        range_err = !fits_signed(imm, 12);
      end
      K_S: begin
        inst      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_err = !fits_signed(imm, 12);
      end
      K_B: begin
        inst      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_err = !fits_signed(imm, 13) || imm[0];
      end
      K_U: begin
        inst      = {imm[31:12], rd, opcode};
        range_err = |imm[11:0];
      end
      K_J: begin
        inst      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_err = !fits_signed(imm, 21) || imm[0];
      end
      // pseudo-op kinds never reach the packer legitimately
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Packs operand fields and immediates into RV32I words; expands LI and FAR into two-word pairs.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_last,
  output logic        out_err
);

  enc_state_e  state, nxt_state;
  pack_req_t   p0, p1;
  logic        single, pseudo;
  logic [31:0] w0, w1, lo_sext, hi_imm;
  logic        e0, e1;
  logic [31:0] pend_inst, nxt_pend, nxt_inst;
  logic        nxt_valid, nxt_last, nxt_err;
  logic        fire, accept;

  // Pseudo-op expansion into up to two real-format packer requests.
  always_comb begin
    p0.kind   = enc_kind_e'(req_kind);
    p0.opcode = req_opcode;
    p0.funct3 = req_funct3;
    p0.funct7 = req_funct7;
    p0.rd     = req_rd;
    p0.rs1    = req_rs1;
    p0.rs2    = req_rs2;
    p0.imm    = req_imm;
    p1        = '0;
    single    = 1'b1;
    pseudo    = 1'b0;
    lo_sext   = {{20{req_imm[11]}}, req_imm[11:0]};
    hi_imm    = {hi20_round(req_imm), 12'h000};
    case (enc_kind_e'(req_kind))
      K_LI: begin
        pseudo = 1'b1;
        if (fits_signed(req_imm, 12)) begin
          p0.kind   = K_I;
          p0.opcode = OP_ART_IMM;
          p0.funct3 = F3_ADD;
          p0.rs1    = 5'd0;
        end else if (req_imm[11:0] == 12'h000) begin
          p0.kind   = K_U;
          p0.opcode = OP_LUI;
        end else begin
          single    = 1'b0;
          p0.kind   = K_U;
          p0.opcode = OP_LUI;
          p0.imm    = hi_imm;
          p1.kind   = K_I;
          p1.opcode = OP_ART_IMM;
          p1.funct3 = F3_ADD;
          p1.rd     = req_rd;
          p1.rs1    = req_rd;
          p1.imm    = lo_sext;
        end
      end
      K_FAR: begin
        pseudo    = 1'b1;
        single    = 1'b0;
        p0.kind   = K_U;
        p0.opcode = OP_AUIPC;
        p0.imm    = hi_imm;
        p1.kind   = K_I;
        p1.opcode = OP_JALR;
        p1.funct3 = F3_ADD;
        p1.rd     = req_rd;
        p1.rs1    = req_rd;
        p1.imm    = lo_sext;
      end
      default: ;
    endcase
  end

  inst_field_pack #(.RESET_INST(RESET_INST)) u_pack0 (
    .kind(p0.kind), .opcode(p0.opcode), .funct3(p0.funct3), .funct7(p0.funct7),
    .rd(p0.rd), .rs1(p0.rs1), .rs2(p0.rs2), .imm(p0.imm),
    .inst(w0), .range_err(e0)
  );

  inst_field_pack #(.RESET_INST(RESET_INST)) u_pack1 (
    .kind(p1.kind), .opcode(p1.opcode), .funct3(p1.funct3), .funct7(p1.funct7),
    .rd(p1.rd), .rs1(p1.rs1), .rs2(p1.rs2), .imm(p1.imm),
    .inst(w1), .range_err(e1)
  );

  always_comb begin
    nxt_state = state;
    nxt_valid = out_valid;
    nxt_inst  = out_inst;
    nxt_last  = out_last;
    nxt_err   = out_err;
    nxt_pend  = pend_inst;
    fire      = out_valid && out_ready;
    req_ready = (state == S_IDLE) || (fire && out_last);
    accept    = req_valid && req_ready;
    case (state)
      S_WORD0: if (fire) begin
        if (out_last) begin
          nxt_state = S_IDLE;
          nxt_valid = 1'b0;
          nxt_inst  = RESET_INST;
          nxt_last  = 1'b0;
          nxt_err   = 1'b0;
        end else begin
          nxt_state = S_WORD1;
          nxt_inst  = pend_inst;
          nxt_last  = 1'b1;
        end
      end
      S_WORD1: if (fire) begin
        nxt_state = S_IDLE;
        nxt_valid = 1'b0;
        nxt_inst  = RESET_INST;
        nxt_last  = 1'b0;
        nxt_err   = 1'b0;
      end
      default: ;
    endcase
    // A new request overrides the drain-to-idle path in the same cycle.
    if (accept) begin
      nxt_state = S_WORD0;
      nxt_valid = 1'b1;
      nxt_inst  = w0;
      nxt_last  = single;
      nxt_err   = pseudo ? 1'b0 : (e0 || (!single && e1));
      nxt_pend  = w1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_inst  <= RESET_INST;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      pend_inst <= RESET_INST;
    end else begin
      state     <= nxt_state;
      out_valid <= nxt_valid;
      out_inst  <= nxt_inst;
      out_last  <= nxt_last;
      out_err   <= nxt_err;
      pend_inst <= nxt_pend;
    end
  end

endmodule
